sound_cmd_mailbox: RTL

//  Command/response mailbox between the 68k main CPU and the io_sound 6502 subsystem.

---
 rtl/sound_cmd_mailbox_pkg.sv | 29 ++
 rtl/sound_cmd_mailbox_if.sv | 50 +++++
 rtl/sound_cmd_mailbox_fifo.sv | 58 +++++
 rtl/sound_cmd_mailbox.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_cmd_mailbox_pkg.sv
// sound_mailbox_pkg -- shared types and constants for the sound command mailbox.
//
// Holds the NMI sequencer state type, the bit positions of the two status
// flags seen by both CPUs, the command byte type, and a helper that packs
// the status word. The command store width does not depend on
// SND_CMD_FIFO_EN, so nothing here is configuration dependent.
package sound_mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } nmi_state_t;

  localparam int STAT_CMD_PENDING = 1;
  localparam int STAT_RESP_FULL   = 0;

  typedef logic [7:0] cmd_byte_t;

  function automatic logic [1:0] pack_status(input logic cmd_pending,
                                             input logic resp_full);
    logic [1:0] s;
    s                   = 2'b00;
    s[STAT_CMD_PENDING] = cmd_pending;
    s[STAT_RESP_FULL]   = resp_full;
    return s;
  endfunction

endpackage

// File: rtl/sound_cmd_mailbox_if.sv
// sound_cmd_mailbox_if -- bus bundle between the 68k/6502 side and the mailbox.
//
// Signals (all synchronous to clk100):
//   m_wr_stb/m_wdata        68k command write strobe and byte
//   m_rd_stb/m_rdata        68k response read strobe and response byte
//   m_rst_wr_stb/m_rst_val  68k write of the sound-reset register
//   m_status, s_status      {cmd_pending, resp_full} to each side
//   MAIN_IRQ_b              low while a response is waiting for the 68k
//   SNDRST_b, SNDNMI_b      reset and NMI lines into io_sound
//   s_rd_stb/s_rdata        6502 command read strobe and command head byte
//   s_wr_stb/s_wdata        6502 response write strobe and byte
//   cmd_overrun             sticky command-overrun flag
// modport master: the CPU side (drives strobes/data, observes status/lines).
// modport slave:  the mailbox itself.
// Identical in both SND_CMD_FIFO_EN configurations.
interface sound_cmd_mailbox_if;
  import sound_mailbox_pkg::*;

  logic      m_wr_stb;
  cmd_byte_t m_wdata;
  logic      m_rd_stb;
  logic [7:0] m_rdata;
  logic      m_rst_wr_stb;
  logic      m_rst_val;
  logic [1:0] m_status;
  logic      MAIN_IRQ_b;
  logic      SNDRST_b;
  logic      SNDNMI_b;
  logic      s_rd_stb;
  cmd_byte_t s_rdata;
  logic      s_wr_stb;
  logic [7:0] s_wdata;
  logic [1:0] s_status;
  logic      cmd_overrun;

  modport master (
    output m_wr_stb, m_wdata, m_rd_stb, m_rst_wr_stb, m_rst_val,
           s_rd_stb, s_wr_stb, s_wdata,
    input  m_rdata, m_status, MAIN_IRQ_b, SNDRST_b, SNDNMI_b,
           s_rdata, s_status, cmd_overrun
  );

  modport slave (
    input  m_wr_stb, m_wdata, m_rd_stb, m_rst_wr_stb, m_rst_val,
           s_rd_stb, s_wr_stb, s_wdata,
    output m_rdata, m_status, MAIN_IRQ_b, SNDRST_b, SNDNMI_b,
           s_rdata, s_status, cmd_overrun
  );

endinterface

// File: rtl/sound_cmd_mailbox_fifo.sv
// snd_cmd_fifo -- small synchronous FIFO holding 68k command bytes.
//
// Only compiled when SND_CMD_FIFO_EN is defined; the default build uses a
// single command latch inside sound_cmd_mailbox instead.
// Ports:
//   clk, rst_b   clock and synchronous active-low reset (clears storage too)
//   clr          synchronous flush of the pointers (sound reset)
//   push, wdata  enqueue one byte; caller guarantees !full or a same-cycle pop
//   pop          dequeue the head; caller guarantees !empty
//   head         current head byte, valid while !empty
//   full, empty  occupancy flags
`ifdef SND_CMD_FIFO_EN
module snd_cmd_fifo
  import sound_mailbox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_b,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  cmd_byte_t wdata,
  output cmd_byte_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_byte_t    mem [0:DEPTH-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`endif

// File: rtl/sound_cmd_mailbox.sv
// sound_cmd_mailbox -- command/response mailbox between the 68k and io_sound.
//
// The 68k writes command bytes; each newly delivered command produces one
// low pulse on SNDNMI_b (NMI_WIDTH cycles low, followed by at least NMI_GAP
// cycles high). The 6502 reads the command and writes a response byte,
// which drops MAIN_IRQ_b until the 68k reads it. The block also owns the
// SNDRST_b register; while it is low the command side and NMI sequencer
// are held clear, but a pending response is kept.
// Ports:
//   clk100  100 MHz system clock
//   rst_b   synchronous active-low reset
//   bus     sound_cmd_mailbox_if.slave (strobes, data, status, IRQ/NMI/reset lines)
// Configuration:
//   SND_CMD_FIFO_EN undefined: single command latch; overwriting an unread
//                              command sets cmd_overrun.
//   SND_CMD_FIFO_EN defined:   FIFO_DEPTH-entry command FIFO (snd_cmd_fifo);
//                              writes to a full FIFO are dropped and set
//                              cmd_overrun.
module sound_cmd_mailbox
  import sound_mailbox_pkg::*;
#(
  parameter int NMI_WIDTH  = 32,
  parameter int NMI_GAP    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk100,
  input  logic                 rst_b,
  sound_cmd_mailbox_if.slave   bus
);

  if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2");
  end

`ifdef SND_CMD_FIFO_EN
  localparam int OWED_MAX = FIFO_DEPTH;
`else
  localparam int OWED_MAX = 1;
`endif
  localparam int OWED_W   = $clog2(OWED_MAX + 1);
  localparam int CNT_TOP  = (NMI_WIDTH > NMI_GAP) ? NMI_WIDTH : NMI_GAP;
  localparam int CNT_W    = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

  localparam logic [OWED_W-1:0] OWED_LIMIT = OWED_W'(OWED_MAX);
  localparam logic [CNT_W-1:0]  WIDTH_LAST = CNT_W'(NMI_WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(NMI_GAP - 1);

  logic        snd_run;      // SNDRST_b register: 1 = io_sound released
  logic        cmd_pending;
  cmd_byte_t   cmd_head;
  logic        overrun_q;
  logic        load_owes;    // a command became visible that deserves its own NMI

  cmd_byte_t   resp_q;
  logic        resp_full;
  logic        irq_b;

  nmi_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             nmi_b;
  logic [OWED_W-1:0] owed_q;
  logic             start_pulse;

  logic        s_wr_ok;

  // ---- Sound reset register ----
  always_ff @(posedge clk100) begin
    if (!rst_b) begin
      snd_run <= 1'b0;
    end else if (bus.m_rst_wr_stb) begin
      snd_run <= bus.m_rst_val;
    end
  end

  // ---- Response path ----
  // 6502 strobes are ignored while io_sound is held in reset, but the 68k
  // may still collect a response written before the reset.
  assign s_wr_ok = bus.s_wr_stb & snd_run;

  always_ff @(posedge clk100) begin
    if (!rst_b) begin
      resp_q    <= 8'h00;
      resp_full <= 1'b0;
      irq_b     <= 1'b1;
    end else if (s_wr_ok) begin
      // A write wins over a same-cycle read so the new byte is not lost.
      resp_q    <= bus.s_wdata;
      resp_full <= 1'b1;
      irq_b     <= 1'b0;
    end else if (bus.m_rd_stb) begin
      resp_full <= 1'b0;
      irq_b     <= 1'b1;
    end
  end

  // ---- Command store ----
`ifdef SND_CMD_FIFO_EN
  logic f_push;
  logic f_pop;
  logic f_full;
  logic f_empty;

  assign f_pop  = bus.s_rd_stb & snd_run & ~f_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
  assign f_push = bus.m_wr_stb & snd_run & (~f_full | f_pop);

  snd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk100),
    .rst_b (rst_b),
    .clr   (~snd_run),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (bus.m_wdata),
    .head  (cmd_head),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk100) begin
    if (!rst_b || !snd_run) begin
      overrun_q <= 1'b0;
    end else if (bus.m_wr_stb && f_full && !f_pop) begin
      overrun_q <= 1'b1;
    end
  end

  assign cmd_pending = ~f_empty;
  assign load_owes   = f_push;
`else
  cmd_byte_t cmd_q;
  logic      pending_q;
  logic      m_wr_ok;
  logic      s_rd_ok;

  assign m_wr_ok = bus.m_wr_stb & snd_run;
  assign s_rd_ok = bus.s_rd_stb & snd_run & pending_q;

  always_ff @(posedge clk100) begin
    if (!rst_b || !snd_run) begin
      cmd_q     <= 8'h00;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (m_wr_ok) begin
      // Same-cycle read consumes the old byte, so only an unread overwrite
      // is an overrun.
      cmd_q     <= bus.m_wdata;
      pending_q <= 1'b1;
      if (pending_q && !s_rd_ok) overrun_q <= 1'b1;
    end else if (s_rd_ok) begin
      pending_q <= 1'b0;
    end
  end

  assign cmd_pending = pending_q;
  assign cmd_head    = cmd_q;
  // Overwriting an unread command reuses the NMI already issued (or owed)
  // for it; only a command landing in an empty or just-read latch owes a pulse.
  assign load_owes   = m_wr_ok & (~pending_q | s_rd_ok);
`endif

  // ---- NMI sequencer ----
  assign start_pulse = (state == IDLE) && (owed_q != '0);

  always_ff @(posedge clk100) begin
    if (!rst_b || !snd_run) begin
      state  <= IDLE;
      cnt    <= '0;
      nmi_b  <= 1'b1;
      owed_q <= '0;
    end else begin
      // Owed-pulse count: +1 per deliverable command, -1 per pulse started.
      case ({load_owes, start_pulse})
        2'b10:   if (owed_q != OWED_LIMIT) owed_q <= owed_q + 1'b1;
        2'b01:   owed_q <= owed_q - 1'b1;
        default: owed_q <= owed_q;
      endcase

      case (state)
        IDLE: begin
          if (start_pulse) begin
            state <= ASSERT;
            nmi_b <= 1'b0;
            cnt   <= '0;
          end
        end
        ASSERT: begin
          if (cnt == WIDTH_LAST) begin
            state <= GAP;
            nmi_b <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          nmi_b <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---- Outputs ----
  assign bus.m_rdata     = resp_q;
  assign bus.MAIN_IRQ_b  = irq_b;
  assign bus.SNDRST_b    = snd_run;
  assign bus.SNDNMI_b    = nmi_b;
  assign bus.s_rdata     = cmd_head;
  assign bus.m_status    = pack_status(cmd_pending, resp_full);
  assign bus.s_status    = pack_status(cmd_pending, resp_full);
  assign bus.cmd_overrun = overrun_q;

endmodule
